// File: rtl/lcd_cmd_seq.sv
`timescale 1ns/1ps
// HD44780-style LCD write sequencer: runs power-up init, then one byte per valid/ready request.
// Latency: accept at edge k -> EN high in cycles k+1+T_SETUP..k+T_SETUP+T_EN; ready again after the exec wait.
// Backpressure: o_ready is high only in IDLE; the requester holds i_valid/i_rs/i_data until accepted.
module lcd_cmd_seq #(
    parameter int T_POWERUP   = 20,
    parameter int T_SETUP     = 2,
    parameter int T_EN        = 4,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 8,
    parameter int T_EXEC_LONG = 40
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN, T_HOLD)),
                                max2(T_EXEC, T_EXEC_LONG));
    localparam int CW    = $clog2(T_MAX) + 1;

    // Counters hold "cycles remaining minus one" so a state lasts exactly T cycles.
    localparam logic [CW-1:0] LD_PWRUP = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_e;

    // Power-up init command list: function set, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h01;
            default: cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [1:0]      step_q, step_d;
    logic            done_q, done_d;
    logic            en;
    logic            long_wait;

    // Clear/home commands need the long execution wait.
    assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

    // State, counter, latched pin values and init progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_PWRUP;
            cnt_q   <= LD_PWRUP;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            step_q  <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // Next-state: count down in each timed state, advance and reload on expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        step_d  = step_q;
        done_d  = done_q;
        en      = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                    step_d  = 2'd0;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_EN_HI;
                    cnt_d   = LD_EN;
                end
            end
            S_EN_HI: begin
                en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = long_wait ? LD_LONG : LD_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    if (!done_q && (step_q != 2'd3)) begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                        rs_d    = 1'b0;
                        data_d  = init_cmd(step_q + 2'd1);
                        step_d  = step_q + 2'd1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (i_valid) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    rs_d    = i_rs;
                    data_d  = i_data;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = LD_PWRUP;
            end
        endcase
    end

    // Reset forces every output low immediately, including a pulse in flight.
    assign o_ready     = !i_reset && (state_q == S_IDLE);
    assign o_init_done = !i_reset && done_q;
    assign o_io_lcd    = i_reset ? 32'h0 : {1'b1, 20'd0, en, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_cmd_seq.sv
`timescale 1ns/1ps
module tb_lcd_cmd_seq;

    localparam int TP  = 20;
    localparam int TS  = 2;
    localparam int TE  = 4;
    localparam int TH  = 2;
    localparam int TX  = 8;
    localparam int TXL = 40;
    localparam int INIT_END = TP + 3 * (TS + TE + TH + TX) + (TS + TE + TH + TXL);

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_rs = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        o_ready;
    logic        o_init_done;
    logic [31:0] o_io_lcd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_cmd_seq #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EN(TE),
        .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .i_rs(i_rs),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_init_done(o_init_done),
        .o_io_lcd(o_io_lcd)
    );

    // ---------------- reference model ----------------
    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic bit is_long(bit rs, logic [7:0] d);
        return !rs && (d inside {8'h01, 8'h02, 8'h03});
    endfunction

    function automatic int txn_len(bit rs, logic [7:0] d);
        return TS + TE + TH + (is_long(rs, d) ? TXL : TX);
    endfunction

    function automatic bit en_at(int off);
        return (off >= TS) && (off < TS + TE);
    endfunction

    function automatic logic [31:0] pins(bit en, bit rs, logic [7:0] d);
        return {1'b1, 20'd0, en, rs, 1'b0, d};
    endfunction

    // {init_done, ready, pins} expected at cycle t after reset release.
    function automatic logic [33:0] init_model(int t);
        int s = TP;
        if (t < TP) return {2'b00, pins(1'b0, 1'b0, 8'h00)};
        for (int i = 0; i < 4; i++) begin
            int len = txn_len(1'b0, init_cmds[i]);
            if (t < s + len) return {2'b00, pins(en_at(t - s), 1'b0, init_cmds[i])};
            s += len;
        end
        return {2'b11, pins(1'b0, 1'b0, 8'h06)};
    endfunction

    // ---------------- EN pulse scoreboard ----------------
    typedef struct packed {
        logic       rs;
        logic [7:0] d;
        logic [7:0] w;
    } pulse_t;

    pulse_t sb[$];
    pulse_t cur;
    int     unstable = 0;
    logic   prev_en = 1'b0;

    always @(negedge clk) begin
        if (o_io_lcd[10] === 1'b1) begin
            if (!prev_en) begin
                cur.rs = o_io_lcd[9];
                cur.d  = o_io_lcd[7:0];
                cur.w  = 8'd1;
            end else begin
                cur.w = cur.w + 8'd1;
                if (o_io_lcd[9] !== cur.rs || o_io_lcd[7:0] !== cur.d) unstable++;
            end
        end else if (prev_en) begin
            sb.push_back(cur);
        end
        prev_en = (o_io_lcd[10] === 1'b1);
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_rs = 1'b0; i_data = 8'h00;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (o_io_lcd !== 32'h0 || o_ready !== 1'b0 || o_init_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: io=%h rdy=%b done=%b, want 0/0/0", o_io_lcd, o_ready, o_init_done);
            end
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        total++;
        if (o_io_lcd !== 32'h8000_0000) begin
            bad++;
            $display("FAIL cycle0_pins: io=%h, want 80000000", o_io_lcd);
        end
    endtask

    task automatic test_init();
        int first_rdy = -1;
        pulse_t exp_p;
        for (int t = 0; t <= INIT_END + 4; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
                i_valid = (t < INIT_END) ? 1'($urandom) : 1'b0;
                i_rs    = 1'($urandom);
                i_data  = 8'($urandom);
                @(negedge clk);
            end
            total++;
            if ({o_init_done, o_ready, o_io_lcd} !== init_model(t)) begin
                bad++;
                $display("FAIL init_cycle t=%0d: done/rdy/io=%b/%b/%h, want %h", t, o_init_done, o_ready, o_io_lcd, init_model(t));
            end
            if (o_ready === 1'b1 && first_rdy < 0) first_rdy = t;
        end
        i_valid = 1'b0;
        total++;
        if (first_rdy != 116) begin
            bad++;
            $display("FAIL init_ready_cycle: got %0d, want 116", first_rdy);
        end
        total++;
        if (sb.size() != 4) begin
            bad++;
            $display("FAIL init_pulse_count: got %0d, want 4", sb.size());
        end
        for (int i = 0; i < 4 && i < sb.size(); i++) begin
            exp_p = '{rs: 1'b0, d: init_cmds[i], w: 8'(TE)};
            total++;
            if (sb[i] !== exp_p) begin
                bad++;
                $display("FAIL init_pulse%0d: rs/d/w=%b/%h/%0d, want 0/%h/%0d", i, sb[i].rs, sb[i].d, sb[i].w, init_cmds[i], TE);
            end
        end
        sb.delete();
    endtask

    task automatic test_single_data();
        logic [31:0] exp;
        pulse_t exp_p;
        i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h41;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            exp = (j >= 3 && j <= 6) ? 32'h8000_0641 : 32'h8000_0241;
            total++;
            if (o_io_lcd !== exp || o_ready !== (j == 17)) begin
                bad++;
                $display("FAIL single_k+%0d: io=%h rdy=%b, want %h rdy=%b", j, o_io_lcd, o_ready, exp, (j == 17));
            end
            if (j < 17) begin
                @(posedge clk); #1;
            end
        end
        exp_p = '{rs: 1'b1, d: 8'h41, w: 8'(TE)};
        total++;
        if (sb.size() != 1 || sb[0] !== exp_p) begin
            bad++;
            $display("FAIL single_pulse: count=%0d first=%h, want 1 and %h", sb.size(), (sb.size() > 0) ? sb[0] : '0, exp_p);
        end
        sb.delete();
    endtask

    task automatic test_exec_wait();
        logic [8:0] items[$] = '{9'h001, 9'h080, 9'h002, 9'h003, 9'h004, 9'h000, 9'h101};
        int off;
        bit r;
        logic [7:0] d;
        pulse_t exp_p;
        repeat (6) begin
            items.push_back({1'($urandom), ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom)});
        end
        foreach (items[n]) begin
            r = items[n][8];
            d = items[n][7:0];
            i_valid = 1'b1; i_rs = r; i_data = d;
            @(posedge clk); #1;
            for (off = 0; off < 300; off++) begin
                i_valid = 1'($urandom); i_rs = 1'($urandom); i_data = 8'($urandom);
                @(negedge clk);
                if (o_ready === 1'b1) break;
                total++;
                if (o_io_lcd !== pins(en_at(off), r, d)) begin
                    bad++;
                    $display("FAIL busy_pins rs=%b d=%h off=%0d: io=%h, want %h", r, d, off, o_io_lcd, pins(en_at(off), r, d));
                end
                @(posedge clk); #1;
            end
            i_valid = 1'b0;
            total++;
            if (off != txn_len(r, d)) begin
                bad++;
                $display("FAIL exec_wait rs=%b d=%h: ready after %0d cycles, want %0d", r, d, off + 1, txn_len(r, d) + 1);
            end
            total++;
            if (o_io_lcd !== pins(1'b0, r, d)) begin
                bad++;
                $display("FAIL idle_pins rs=%b d=%h: io=%h, want %h", r, d, o_io_lcd, pins(1'b0, r, d));
            end
            exp_p = '{rs: r, d: d, w: 8'(TE)};
            total++;
            if (sb.size() != 1 || sb[0] !== exp_p) begin
                bad++;
                $display("FAIL txn_pulse rs=%b d=%h: count=%0d first=%h, want 1 and %h", r, d, sb.size(), (sb.size() > 0) ? sb[0] : '0, exp_p);
            end
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h48, 8'h49, 8'h21};
        int acc[$];
        int n = 0;
        bit took;
        pulse_t exp_p;
        i_valid = 1'b1; i_rs = 1'b1; i_data = bytes[0];
        for (int c = 0; c < 200 && n < 3; c++) begin
            took = (o_ready === 1'b1);
            if (took) acc.push_back(c);
            @(posedge clk); #1;
            if (took) begin
                n++;
                if (n < 3) i_data = bytes[n];
                else i_valid = 1'b0;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int w = 0; w < 100 && o_ready !== 1'b1; w++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        total++;
        if (acc.size() != 3) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d, want 3", acc.size());
        end else begin
            total++;
            if (acc[1] - acc[0] != 17 || acc[2] - acc[0] != 34) begin
                bad++;
                $display("FAIL b2b_spacing: +%0d/+%0d, want +17/+34", acc[1] - acc[0], acc[2] - acc[0]);
            end
        end
        total++;
        if (sb.size() != 3) begin
            bad++;
            $display("FAIL b2b_pulse_count: got %0d, want 3", sb.size());
        end
        for (int i = 0; i < 3 && i < sb.size(); i++) begin
            exp_p = '{rs: 1'b1, d: bytes[i], w: 8'(TE)};
            total++;
            if (sb[i] !== exp_p) begin
                bad++;
                $display("FAIL b2b_pulse%0d: got %h, want %h", i, sb[i], exp_p);
            end
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL en_stability: %0d pin changes while EN=1, want 0", unstable);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int t;
        bit seen = 1'b0;
        pulse_t exp_p;
        i_valid = 1'b1; i_rs = 1'($urandom); i_data = 8'($urandom);
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (o_io_lcd[10] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_en_seen: EN never rose, want EN=1 within %0d cycles", TS + 1);
        end
        i_reset = 1'b1;
        #1;
        total++;
        if (o_io_lcd !== 32'h0 || o_ready !== 1'b0 || o_init_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: io=%h rdy=%b done=%b, want 0/0/0", o_io_lcd, o_ready, o_init_done);
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        total++;
        if (o_io_lcd !== 32'h8000_0000 || o_init_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_cycle0: io=%h done=%b, want 80000000/0", o_io_lcd, o_init_done);
        end
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        for (t = 1; t < 300; t++) begin
            if (o_init_done === 1'b1) break;
            @(posedge clk); #1;
            @(negedge clk);
        end
        total++;
        if (t != INIT_END || o_ready !== 1'b1 || o_io_lcd !== pins(1'b0, 1'b0, 8'h06)) begin
            bad++;
            $display("FAIL mid_reinit: done at %0d rdy=%b io=%h, want %0d/1/%h", t, o_ready, o_io_lcd, INIT_END, pins(1'b0, 1'b0, 8'h06));
        end
        total++;
        if (sb.size() != 4) begin
            bad++;
            $display("FAIL mid_pulse_count: got %0d, want 4", sb.size());
        end
        for (int i = 0; i < 4 && i < sb.size(); i++) begin
            exp_p = '{rs: 1'b0, d: init_cmds[i], w: 8'(TE)};
            total++;
            if (sb[i] !== exp_p) begin
                bad++;
                $display("FAIL mid_pulse%0d: got %h, want %h", i, sb[i], exp_p);
            end
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_data();
        test_exec_wait();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
